// File: rtl/bamse_ioc_pkg.sv
// Shared constants for the bamse interrupt-on-change port controller:
// register offsets on the PicoBlaze3 port bus and the request FSM encoding.
package bamse_ioc_pkg;

    localparam logic [7:0] REG_LEVEL = 8'd0;
    localparam logic [7:0] REG_POS   = 8'd1;
    localparam logic [7:0] REG_NEG   = 8'd2;
    localparam logic [7:0] REG_FLAG  = 8'd3;
    localparam logic [7:0] REG_IE    = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } ioc_state_t;

endpackage

// File: rtl/bamse_sync_edge.sv
// One pin of the IOC: multi-flop synchroniser followed by a registered,
// enable-qualified rising/falling edge detector.
module bamse_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic pos_en,
    input  logic neg_en,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int unsigned MSB = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_d_q;

    assign lvl = sync_q[MSB];

    // Edge pulses are registered so FLAG sees them one cycle after the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            lvl_d_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            lvl_d_q <= sync_q[MSB];
            rise    <= sync_q[MSB] & ~lvl_d_q & pos_en;
            fall    <= ~sync_q[MSB] & lvl_d_q & neg_en;
        end
    end

endmodule

// File: rtl/bamse_ioc.sv
// Interrupt-on-change controller: per-pin edge flags, PicoBlaze3 port-bus
// registers and an interrupt request FSM held until interrupt_ack.
module bamse_ioc
    import bamse_ioc_pkg::*;
#(
    parameter int unsigned N_PINS      = 3,
    parameter logic [7:0]  BASE_ADDR   = 8'h10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_PINS-1:0] pins,
    input  logic [7:0]        port_id,
    input  logic [7:0]        out_port,
    input  logic              write_strobe,
    input  logic              read_strobe,
    output logic [7:0]        in_port,
    output logic              interrupt,
    input  logic              interrupt_ack
);

    localparam logic [7:0] ADDR_LEVEL = BASE_ADDR + REG_LEVEL;
    localparam logic [7:0] ADDR_POS   = BASE_ADDR + REG_POS;
    localparam logic [7:0] ADDR_NEG   = BASE_ADDR + REG_NEG;
    localparam logic [7:0] ADDR_FLAG  = BASE_ADDR + REG_FLAG;
    localparam logic [7:0] ADDR_IE    = BASE_ADDR + REG_IE;

    logic [N_PINS-1:0] lvl;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] pos_q;
    logic [N_PINS-1:0] neg_q;
    logic [N_PINS-1:0] flag_q;
    logic              ie_q;

    logic [N_PINS-1:0] flag_clr_c;
    logic [N_PINS-1:0] flag_d_c;
    logic              wr_pos_c;
    logic              wr_neg_c;
    logic              wr_flag_c;
    logic              wr_ie_c;
    logic [7:0]        rd_data_c;
    ioc_state_t        state_q;
    ioc_state_t        state_d;

    // Reads carry no side effects, so read_strobe is only sunk here.
    logic unused_c;
    assign unused_c = ^{read_strobe, out_port};

    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        bamse_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (pins[i]),
            .pos_en(pos_q[i]),
            .neg_en(neg_q[i]),
            .lvl   (lvl[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign wr_pos_c   = write_strobe && (port_id == ADDR_POS);
    assign wr_neg_c   = write_strobe && (port_id == ADDR_NEG);
    assign wr_flag_c  = write_strobe && (port_id == ADDR_FLAG);
    assign wr_ie_c    = write_strobe && (port_id == ADDR_IE);

    // Set has priority over a write-one-to-clear in the same cycle.
    assign flag_clr_c = wr_flag_c ? out_port[N_PINS-1:0] : '0;
    assign flag_d_c   = (flag_q & ~flag_clr_c) | rise | fall;

    always_comb begin
        rd_data_c = 8'h00;
        case (port_id)
            ADDR_LEVEL: rd_data_c = 8'(lvl);
            ADDR_POS:   rd_data_c = 8'(pos_q);
            ADDR_NEG:   rd_data_c = 8'(neg_q);
            ADDR_FLAG:  rd_data_c = 8'(flag_q);
            ADDR_IE:    rd_data_c = 8'(ie_q);
            default:    rd_data_c = 8'h00;
        endcase
    end

    // Request FSM; SERVICE only exits once every flag has been cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ie_q && (|flag_q)) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (interrupt_ack)                 state_d = ST_SERVICE;
                else if (!ie_q || (flag_q == '0))  state_d = ST_IDLE;
            end
            ST_SERVICE: begin
                if (flag_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            interrupt <= 1'b0;
            pos_q     <= '0;
            neg_q     <= '0;
            flag_q    <= '0;
            ie_q      <= 1'b0;
            in_port   <= 8'h00;
        end else begin
            state_q   <= state_d;
            interrupt <= (state_d == ST_REQ);
            flag_q    <= flag_d_c;
            in_port   <= rd_data_c;
            if (wr_pos_c) pos_q <= out_port[N_PINS-1:0];
            if (wr_neg_c) neg_q <= out_port[N_PINS-1:0];
            if (wr_ie_c)  ie_q  <= out_port[0];
        end
    end

endmodule
